// File: rtl/clusterv_mem_arb_2x1.sv
// Two-initiator Wishbone arbiter in front of the 8 KB cluster memory controller.
// Round-robin on simultaneous requests, grant held for the whole initiator cycle,
// purely combinational request/response steering with no buffering.
module clusterv_mem_arb_2x1 #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic [ADR_WIDTH-1:0]     i0_adr,
    input  logic [DAT_WIDTH-1:0]     i0_dat_w,
    input  logic [DAT_WIDTH/8-1:0]   i0_sel,
    input  logic                     i0_cyc,
    input  logic                     i0_stb,
    input  logic                     i0_we,
    output logic [DAT_WIDTH-1:0]     i0_dat_r,
    output logic                     i0_ack,
    output logic                     i0_err,

    input  logic [ADR_WIDTH-1:0]     i1_adr,
    input  logic [DAT_WIDTH-1:0]     i1_dat_w,
    input  logic [DAT_WIDTH/8-1:0]   i1_sel,
    input  logic                     i1_cyc,
    input  logic                     i1_stb,
    input  logic                     i1_we,
    output logic [DAT_WIDTH-1:0]     i1_dat_r,
    output logic                     i1_ack,
    output logic                     i1_err,

    output logic [ADR_WIDTH-1:0]     t_adr,
    output logic [DAT_WIDTH-1:0]     t_dat_w,
    output logic [DAT_WIDTH/8-1:0]   t_sel,
    output logic                     t_cyc,
    output logic                     t_stb,
    output logic                     t_we,
    input  logic [DAT_WIDTH-1:0]     t_dat_r,
    input  logic                     t_ack,
    input  logic                     t_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    // last_gnt = index of the initiator granted most recently; a tie goes to the other one
    logic       last_gnt;
    logic       last_gnt_nxt;

    // Next-state logic: arbitrate only from IDLE, hold a grant until its cyc drops
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (i0_cyc && i1_cyc) begin
                    if (last_gnt) begin
                        state_nxt    = GNT0;
                        last_gnt_nxt = 1'b0;
                    end else begin
                        state_nxt    = GNT1;
                        last_gnt_nxt = 1'b1;
                    end
                end else if (i0_cyc) begin
                    state_nxt    = GNT0;
                    last_gnt_nxt = 1'b0;
                end else if (i1_cyc) begin
                    state_nxt    = GNT1;
                    last_gnt_nxt = 1'b1;
                end
            end
            GNT0:    if (!i0_cyc) state_nxt = IDLE;
            GNT1:    if (!i1_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; reset leaves last_gnt=1 so i0 wins the first tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Steer the granted initiator onto the target and route responses back to it only
    always_comb begin
        t_adr   = '0;
        t_dat_w = '0;
        t_sel   = '0;
        t_cyc   = 1'b0;
        t_stb   = 1'b0;
        t_we    = 1'b0;
        i0_ack  = 1'b0;
        i0_err  = 1'b0;
        i1_ack  = 1'b0;
        i1_err  = 1'b0;
        case (state)
            GNT0: begin
                t_adr   = i0_adr;
                t_dat_w = i0_dat_w;
                t_sel   = i0_sel;
                t_cyc   = i0_cyc;
                t_stb   = i0_stb;
                t_we    = i0_we;
                i0_ack  = t_ack;
                i0_err  = t_err;
            end
            GNT1: begin
                t_adr   = i1_adr;
                t_dat_w = i1_dat_w;
                t_sel   = i1_sel;
                t_cyc   = i1_cyc;
                t_stb   = i1_stb;
                t_we    = i1_we;
                i1_ack  = t_ack;
                i1_err  = t_err;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; initiators qualify it with their own ack
    assign i0_dat_r = t_dat_r;
    assign i1_dat_r = t_dat_r;

endmodule

// File: doc/clusterv_mem_arb_2x1.md
CLUSTERV_MEM_ARB_2X1 -- requirements
Module: clusterv_mem_arb_2x1

Interface
REQ-001 Parameter: ADR_WIDTH, 32, address width of all Wishbone ports.
REQ-002 Parameter: DAT_WIDTH, 32, data width; select width is DAT_WIDTH/8.
REQ-003 Port: clock  input  1  single clock; all state on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Ports: i0_adr, i1_adr  input  ADR_WIDTH  initiator addresses.
REQ-006 Ports: i0_dat_w, i1_dat_w  input  DAT_WIDTH  initiator write data.
REQ-007 Ports: i0_sel, i1_sel  input  DAT_WIDTH/8  initiator byte selects.
REQ-008 Ports: i0_cyc, i1_cyc, i0_stb, i1_stb, i0_we, i1_we  input  1  initiator cycle, strobe, write enable.
REQ-009 Ports: i0_dat_r, i1_dat_r  output  DAT_WIDTH  read data to initiators.
REQ-010 Ports: i0_ack, i1_ack, i0_err, i1_err  output  1  initiator acknowledge and error.
REQ-011 Ports: t_adr  output  ADR_WIDTH; t_dat_w  output  DAT_WIDTH; t_sel  output  DAT_WIDTH/8. All drive the SRAM controller target port.
REQ-012 Ports: t_cyc, t_stb, t_we  output  1  target cycle, strobe, write enable.
REQ-013 Ports: t_dat_r  input  DAT_WIDTH; t_ack, t_err  input  1  target responses.

Function
REQ-014 The block shall arbitrate two Wishbone initiators onto one target (the 8 KB cluster memory controller) using a state machine with states IDLE, GNT0 and GNT1.
REQ-015 IDLE transitions:
- i0_cyc only -> GNT0.
- i1_cyc only -> GNT1.
- Both -> the initiator opposite last_gnt.
- Neither -> stay in IDLE.
REQ-016 last_gnt shall be a 1-bit register updated on every IDLE->GNTx transition, so simultaneous requests alternate round-robin.
REQ-017 GNTx shall hold while ix_cyc=1 and return to IDLE on the first clock edge where ix_cyc=0; no other event may preempt a grant.
REQ-018 Grant latency:
- A request seen in IDLE reaches the target one clock later.
- After release, at least one IDLE cycle passes before the next grant.
REQ-019 In GNTx, t_adr, t_dat_w, t_sel, t_we, t_cyc and t_stb shall equal the granted initiator's signals combinationally.
REQ-020 In IDLE, t_cyc, t_stb and t_we shall be 0, and t_adr, t_dat_w and t_sel shall be all-zero.
REQ-021 ix_ack shall equal t_ack and ix_err shall equal t_err only while GNTx; otherwise both shall be 0.
REQ-022 i0_dat_r and i1_dat_r shall both equal t_dat_r at all times (broadcast); initiators qualify data with ack.
REQ-023 Back-to-back transfers within one held cyc (stb re-asserted) shall pass through without re-arbitration or added wait states.
REQ-024 If a granted initiator drops cyc in the same cycle the target asserts ack, the ack shall still reach that initiator combinationally, and the state shall go to IDLE on the next edge.
REQ-025 The block shall add no buffering: exactly one target transfer is outstanding per strobe, and a non-granted initiator sees ack=err=0 indefinitely.

Reset
REQ-026 While reset=1: state shall be IDLE, last_gnt=1 (i0 wins the first tie), all t_ control outputs and all ack/err outputs 0.
REQ-027 Reset asserted mid-transfer shall abandon the grant immediately; no ack may reach either initiator after reset rises.

Verification
REQ-028 i0 single read at adr 0x100, target ack on the 2nd cycle with t_dat_r=0xDEADBEEF -> t_cyc rises 1 clock after i0_cyc, and i0_ack=1 with i0_dat_r=0xDEADBEEF while i1_ack=0.
REQ-029 i0 and i1 assert cyc on the same edge after reset -> i0 granted first; after i0 releases, i1 granted following one IDLE cycle; a repeated tie then grants i0.
REQ-030 i1 holds cyc across 4 write strobes (sel=0xF, then 0x1, 0x2, 0x4) while i0 requests -> all 4 writes reach the target with sel intact, and i0 is granted only after i1_cyc drops.
REQ-031 Target asserts t_err on an i0 transfer -> i0_err=1 for that cycle only, i1_err=0, and the grant persists until i0_cyc=0.
REQ-032 Reset pulsed during GNT1 with target ack pending -> all outputs 0 within the reset cycle, state IDLE, and the next tie goes to i0.
REQ-033 ack coincident with i0_cyc falling -> i0_ack=1 in that cycle, t_cyc=0 on the next cycle, and no spurious transfer is issued.
